// File: rtl/alu_pkg.sv
// Shared types and constants for the add/sub/logic pipeline.
package alu_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SLT  = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // Stage-1 payload: everything stage 2 needs to finish the operation.
    typedef struct packed {
        logic [ALU_W-1:0] g;
        logic [ALU_W-1:0] p;
        logic             cin;
        alu_op_t          op;
        logic             a_msb;
        logic             b_msb;
    } s1_t;

endpackage

// File: rtl/alu_addsub_pipe_if.sv
// Operand/result handshake bundle between issue logic and writeback.
interface alu_addsub_pipe_if;
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [ALU_W-1:0] in_a;
    logic [ALU_W-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [ALU_W-1:0] out_result;
    logic             out_n;
    logic             out_z;
    logic             out_c;
    logic             out_v;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_n, out_z, out_c, out_v
    );

    // The ALU itself.
    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_n, out_z, out_c, out_v
    );

endinterface

// File: rtl/alu_addsub_pipe_lac32.sv
// 32-bit lookahead carry tree: parallel-prefix (log-depth) group
// generate/propagate, then every carry is resolved against Cin at once.
module lac32 (
    output logic [31:0] c,
    output logic        gout,
    output logic        pout,
    input  logic        Cin,
    input  logic [31:0] g,
    input  logic [31:0] p
);

    logic [31:0] grp_g;
    logic [31:0] grp_p;

    // Prefix combine in place; walking bits high-to-low means bit i-d
    // still holds the previous level's value when bit i reads it.
    always_comb begin
        grp_g = g;
        grp_p = p;
        for (int lvl = 0; lvl < 5; lvl++) begin
            for (int i = 31; i >= 0; i--) begin
                if (i >= (1 << lvl)) begin
                    grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i - (1 << lvl)]);
                    grp_p[i] = grp_p[i] & grp_p[i - (1 << lvl)];
                end
            end
        end
    end

    // grp_g[i]/grp_p[i] now span bits i..0, so carry into i+1 follows directly.
    assign c    = {grp_g[30:0] | (grp_p[30:0] & {31{Cin}}), Cin};
    assign gout = grp_g[31];
    assign pout = grp_p[31];

endmodule

// File: rtl/alu_addsub_pipe.sv
// Two-stage add/sub/logic unit: stage 1 forms g/p/cin, stage 2 resolves
// carries and registers result plus N/Z/C/V flags.
module alu_addsub_pipe
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_addsub_pipe_if.slave  bus
);

    logic         s1_valid_q, s1_valid_d;
    s1_t          s1_q, s1_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_result_q, out_result_d;
    flags_t       out_flags_q, out_flags_d;

    logic         adv2;
    logic         in_xfer;
    alu_op_t      in_op_e;
    logic [W-1:0] b_eff;
    logic         inv_b;

    logic [31:0]  carry;
    logic         gout;
    logic         pout;
    logic         cout;
    logic [W-1:0] sum;
    logic         ovf;
    logic [W-1:0] res;
    flags_t       flg;

    assign adv2        = !out_valid_q | bus.out_ready;
    assign bus.in_ready = !s1_valid_q | adv2;
    assign in_xfer     = bus.in_valid & bus.in_ready;
    assign in_op_e     = alu_op_t'(bus.in_op);
    assign inv_b       = (in_op_e == OP_SUB) || (in_op_e == OP_SLT);
    assign b_eff       = inv_b ? ~bus.in_b : bus.in_b;

    // Stage 1: capture on input transfer, drain when stage 2 takes it.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (in_xfer) begin
            s1_valid_d = 1'b1;
            s1_d.g     = bus.in_a & b_eff;
            s1_d.p     = bus.in_a ^ b_eff;
            s1_d.cin   = inv_b;
            s1_d.op    = in_op_e;
            s1_d.a_msb = bus.in_a[W-1];
            s1_d.b_msb = b_eff[W-1];
        end else if (adv2) begin
            s1_valid_d = 1'b0;
        end
    end

    lac32 u_lac32 (
        .c    (carry),
        .gout (gout),
        .pout (pout),
        .Cin  (s1_q.cin),
        .g    (s1_q.g),
        .p    (s1_q.p)
    );

    // Stage 2 combinational: sum, overflow and per-op result/flags.
    always_comb begin
        cout = gout | (pout & s1_q.cin);
        sum  = s1_q.p ^ carry;
        ovf  = (s1_q.a_msb == s1_q.b_msb) & (sum[W-1] != s1_q.a_msb);
        res  = sum;
        flg  = '0;
        case (s1_q.op)
            OP_AND: res = s1_q.g;
            OP_OR:  res = s1_q.g | s1_q.p;
            OP_XOR: res = s1_q.p;
            OP_SLT: begin
                res   = {{(W-1){1'b0}}, sum[W-1] ^ ovf};
                flg.c = cout;
                flg.v = ovf;
            end
            default: begin
                res   = sum;
                flg.c = cout;
                flg.v = ovf;
            end
        endcase
        flg.n = res[W-1];
        flg.z = (res == '0);
    end

    // Output register: advances on adv2, otherwise holds stable.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_result_d = res;
                out_flags_d  = flg;
            end
        end
    end

    // State update with synchronous reset taking priority over handshakes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_q         <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_q         <= s1_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_n      = out_flags_q.n;
    assign bus.out_z      = out_flags_q.z;
    assign bus.out_c      = out_flags_q.c;
    assign bus.out_v      = out_flags_q.v;

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// Scoreboard bench for alu_addsub_pipe: driver pushes expected results,
// monitor pops and compares whenever an output transfers.
module tb_alu_addsub_pipe;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_addsub_pipe_if bus ();

    alu_addsub_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;    // {n,z,c,v}
        bit          lat;
        int          icyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   pops = 0;
    int   accepts = 0;
    bit   rand_bp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        exp_t        e;
        longint      sa, sb_, ls;
        logic [32:0] w;
        logic        c, v;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd1, 3'd5: begin
                r  = a - b;
                c  = (a >= b);
                ls = sa - sb_;
                v  = (ls > 64'sd2147483647) || (ls < -64'sd2147483648);
                if (op == 3'd5) r = (sa < sb_) ? 32'd1 : 32'd0;
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            default: begin
                w  = {1'b0, a} + {1'b0, b};
                r  = w[31:0];
                c  = w[32];
                ls = sa + sb_;
                v  = (ls > 64'sd2147483647) || (ls < -64'sd2147483648);
            end
        endcase
        e.res  = r;
        e.fl   = {r[31], (r == 32'd0), c, v};
        e.lat  = 1'b0;
        e.icyc = 0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] r, input logic [3:0] fl, input bit lat);
        exp_t e;
        e.res = r; e.fl = fl; e.lat = lat; e.icyc = 0;
        return e;
    endfunction

    // Present one operation and hold it until accepted; expectation enters
    // the scoreboard in the cycle the transfer happens.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input exp_t e);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.icyc = cyc;
                sb.push_back(e);
                accepts++;
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL accept_timeout actual=no_accept required=accept op=%0d", op);
        bus.in_valid = 1'b0;
    endtask

    // Monitor: compares every output transfer against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output actual=%h required=none", bus.out_result);
            end else begin
                e = sb.pop_front();
                chk("result", bus.out_result, e.res);
                chk("flags_nzcv", {28'd0, bus.out_n, bus.out_z, bus.out_c, bus.out_v}, {28'd0, e.fl});
                if (e.lat) chk("latency", 32'(cyc - e.icyc), 32'd2);
                pops++;
            end
        end
    end

    // Random backpressure on the output side.
    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check_idle_reset_state(input string tag);
        chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        chk({tag, "_result"}, bus.out_result, 32'd0);
        chk({tag, "_flags"}, {28'd0, bus.out_n, bus.out_z, bus.out_c, bus.out_v}, 32'd0);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d_pending required=0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] spec_vals[4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        int          base;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed: carry/zero with latency, overflow, SLT, logic, reserved ops.
        issue(32'hFFFF_FFFF, 32'h1, 3'd0, mk(32'h0, 4'b0110, 1'b1));
        drain();
        issue(32'h7FFF_FFFF, 32'h1, 3'd0, mk(32'h8000_0000, 4'b1001, 1'b0));
        issue(32'h8000_0000, 32'h1, 3'd1, mk(32'h7FFF_FFFF, 4'b0011, 1'b0));
        issue(32'hFFFF_FFFE, 32'h3, 3'd5, mk(32'h1, 4'b0010, 1'b0));
        issue(32'h5, 32'hFFFF_FFFF, 3'd5, mk(32'h0, 4'b0100, 1'b0));
        issue(32'hF0F0_1234, 32'h0FF0_FF00, 3'd2, mk(32'h00F0_1200, 4'b0000, 1'b0));
        issue(32'hF0F0_1234, 32'h0FF0_FF00, 3'd3, mk(32'hFFF0_FF34, 4'b1000, 1'b0));
        issue(32'hF0F0_1234, 32'h0FF0_FF00, 3'd4, mk(32'hFF00_ED34, 4'b1000, 1'b0));
        issue(32'h7FFF_FFFF, 32'h1, 3'd6, mk(32'h8000_0000, 4'b1001, 1'b0));
        issue(32'hFFFF_FFFF, 32'h1, 3'd7, mk(32'h0, 4'b0110, 1'b0));
        drain();

        // Backpressure: four back-to-back ADDs into a stalled output.
        bus.out_ready = 1'b0;
        base = accepts;
        fork
            begin
                for (int j = 0; j < 4; j++)
                    issue(32'h1000 * (j + 1), 32'd7 + j, 3'd0, model(32'h1000 * (j + 1), 32'd7 + j, 3'd0));
            end
        join_none
        repeat (6) @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_accepts", 32'(accepts - base), 32'd2);
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_hold_result", bus.out_result, 32'h1007);
        end
        @(posedge clk);
        #1;
        base = pops;
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            chk("bp_drain_rate", 32'(pops - base), 32'(k));
        end
        drain();

        // Reset with both stages full.
        bus.out_ready = 1'b0;
        issue(32'h11, 32'h22, 3'd0, model(32'h11, 32'h22, 3'd0));
        issue(32'h33, 32'h44, 3'd1, model(32'h33, 32'h44, 3'd1));
        chk("pre_rst_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        check_idle_reset_state("midrst");
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_no_stale", {31'd0, bus.out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Random traffic against the reference model with random stalls.
        rand_bp = 1'b1;
        for (int n = 0; n < 300; n++) begin
            ra  = ($urandom_range(0, 3) == 0) ? spec_vals[$urandom_range(0, 3)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? spec_vals[$urandom_range(0, 3)] : $urandom;
            rop = 3'($urandom_range(0, 7));
            issue(ra, rb, rop, model(ra, rb, rop));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_bp = 1'b0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_addsub_pipe.md
Name: alu_addsub_pipe

Overview:
- Two-stage pipelined 32-bit add/subtract/logic unit with a valid/ready handshake on both sides.
- Stage 1 (input side) forms the per-bit generate/propagate vectors and the carry-in from the operands and the opcode.
- Stage 2 resolves all carries with a 32-bit lookahead carry tree, forms the result and N/Z/C/V flags, and holds them in an output register.
- Sits between the register-read/issue logic upstream and the writeback/flag register downstream.

Parameters:
- W, 32, datapath width; only 32 is supported because the carry tree is fixed at 32 bits.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands and op are presented
- in_ready  out  1  unit accepts the input this cycle
- in_a  in  32  operand A
- in_b  in  32  operand B
- in_op  in  3  0=ADD 1=SUB 2=AND 3=OR 4=XOR 5=SLT (signed set-less-than); 6 and 7 are reserved and behave as ADD
- out_valid  out  1  result is valid
- out_ready  in  1  consumer takes the result
- out_result  out  32  result
- out_n, out_z, out_c, out_v  out  1 each  negative, zero, carry-out, signed overflow

Behaviour:
- Reset: when rst_n=0 at a clock edge, s1_valid and out_valid clear to 0, and out_result and all flags clear to 0. Reset takes priority over any handshake in that cycle, and any in-flight operations are discarded.
- Handshake: an input transfers when in_valid & in_ready; an output transfers when out_valid & out_ready.
- Pipeline advance: adv2 = !out_valid | out_ready.
- Input ready: in_ready = !s1_valid | adv2, combinational. No combinational path exists from in_valid to out_valid.
- Stage 1 capture (on an input transfer):
  - b' = ~in_b for SUB and SLT, otherwise in_b.
  - g = in_a & b'; p = in_a ^ b'.
  - cin = 1 for SUB and SLT, otherwise 0.
  - Also captured: op and a[31], b'[31]. s1_valid is set.
  - If s1 holds a value, adv2=1 and no new input arrives, s1_valid clears.
- Stage 2:
  - The carry tree gives c[i] = carry into bit i, with c[0]=cin, and cout = gout | (pout & cin).
  - sum = p ^ c.
  - On adv2, out_valid takes s1_valid; when s1_valid=1 the result and flags are also loaded.
  - While out_valid=1 and out_ready=0, out_result and the flags are held stable and s1 is held (it fills at most once).
- Result by op:
  - ADD/SUB: sum.
  - AND: g, which equals a&b.
  - OR: g|p.
  - XOR: p.
  - SLT: {31'b0, sum[31]^v}.
- Flags:
  - n = result[31]; z = (result==0).
  - c = cout for ADD/SUB/SLT, otherwise 0. For SUB, c=1 means no borrow.
  - v = (a[31]==b'[31]) & (sum[31]!=a[31]) for ADD/SUB/SLT, otherwise 0.
- Latency and throughput: 2 cycles from the input transfer to out_valid with no backpressure; sustained throughput is 1 per cycle.
- Boundary cases:
  - When full with out_ready=0, in_ready=0.
  - When full and out_ready=1, the simultaneous input accept and output retire both happen in the same cycle.
  - Reserved opcodes produce ADD results and ADD flags.

Decomposition:
- Shared package alu_pkg holds:
  - alu_op_t, the 3-bit enum with the values above;
  - ALU_W=32;
  - the flags_t struct {n,z,c,v}.
- One sub-module, lac32, does the carry resolution: ports c[31:0], gout, pout, Cin, g[31:0], p[31:0]. Stage 2 instantiates it once; everything else is local RTL.

Test Plan:
1. ADD: a=0xFFFFFFFF, b=0x00000001 -> result 0x00000000, z=1, c=1, v=0, n=0; out_valid asserts exactly 2 cycles after the accept.
2. Overflow: ADD a=0x7FFFFFFF, b=1 -> 0x80000000, n=1, v=1, c=0. SUB a=0x80000000, b=1 -> 0x7FFFFFFF, v=1, c=1.
3. SLT: a=0xFFFFFFFE (-2), b=3 -> result 1. a=5, b=0xFFFFFFFF -> result 0.
4. Logic ops: a=0xF0F0_1234, b=0x0FF0_FF00 -> AND 0x00F0_1200, OR 0xFFF0_FF34, XOR 0xFF00_ED34; c=v=0.
5. Backpressure: stream 4 ADDs back-to-back with out_ready=0 from cycle 2 -> in_ready drops after 2 accepts and the output holds stable. Raising out_ready then delivers all 4 in order, 1 per cycle, with none lost or duplicated.
6. Reset mid-operation: drive rst_n=0 for one cycle with both stages full -> next cycle out_valid=0, in_ready=1, result=0, and no stale result appears afterwards.
